// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: redirect/stall/predict next-PC selection with an optional
// direct-mapped BTB (2-bit counters), enabled by defining FETCH_PC_GEN_BTB_EN.
module fetch_pc_gen #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
   parameter int               BTB_DEPTH    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             StallF,
   input  logic             RedirectE,
   input  logic [WIDTH-1:0] RedirectPCE,
   input  logic             BranchUpdE,
   input  logic [WIDTH-1:0] UpdPCE,
   input  logic [WIDTH-1:0] UpdTargetE,
   input  logic             UpdTakenE,
   output logic [WIDTH-1:0] PCF,
   output logic [WIDTH-1:0] PCPlus4F,
   output logic             PredTakenF,
   output logic [WIDTH-1:0] PredTargetF
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pc_plus4_s;
   logic [WIDTH-1:0] redirect_pc_s;
   logic             pred_taken_s;
   logic [WIDTH-1:0] pred_target_s;
   logic             unused_s;

   assign pc_plus4_s    = pc_q + {{(WIDTH-3){1'b0}}, 3'b100};
   assign redirect_pc_s = {RedirectPCE[WIDTH-1:2], 2'b00};

`ifdef FETCH_PC_GEN_BTB_EN
   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = WIDTH - IDX_W - 2;

   logic             valid_q [BTB_DEPTH];
   logic             valid_d [BTB_DEPTH];
   logic [TAG_W-1:0] tag_q   [BTB_DEPTH];
   logic [TAG_W-1:0] tag_d   [BTB_DEPTH];
   logic [WIDTH-3:0] tgt_q   [BTB_DEPTH];
   logic [WIDTH-3:0] tgt_d   [BTB_DEPTH];
   logic [1:0]       cnt_q   [BTB_DEPTH];
   logic [1:0]       cnt_d   [BTB_DEPTH];

   logic [IDX_W-1:0] rd_idx_s, wr_idx_s;
   logic [TAG_W-1:0] rd_tag_s, wr_tag_s;
   logic             rd_hit_s, wr_hit_s;

   assign rd_idx_s = pc_q[IDX_W+1:2];
   assign rd_tag_s = pc_q[WIDTH-1:IDX_W+2];
   assign wr_idx_s = UpdPCE[IDX_W+1:2];
   assign wr_tag_s = UpdPCE[WIDTH-1:IDX_W+2];
   assign rd_hit_s = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s);
   assign wr_hit_s = valid_q[wr_idx_s] && (tag_q[wr_idx_s] == wr_tag_s);

   // Lookup reads registered contents only, so a same-cycle update is seen next cycle.
   assign pred_taken_s  = rd_hit_s && cnt_q[rd_idx_s][1];
   assign pred_target_s = pred_taken_s ? {tgt_q[rd_idx_s], 2'b00} : pc_plus4_s;
   assign unused_s      = &{1'b0, RedirectPCE[1:0], UpdPCE[1:0], UpdTargetE[1:0]};

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      if (BranchUpdE && wr_hit_s) begin
         if (UpdTakenE) begin
            cnt_d[wr_idx_s] = (cnt_q[wr_idx_s] == 2'b11) ? 2'b11 : cnt_q[wr_idx_s] + 2'b01;
            tgt_d[wr_idx_s] = UpdTargetE[WIDTH-1:2];
         end else begin
            cnt_d[wr_idx_s] = (cnt_q[wr_idx_s] == 2'b00) ? 2'b00 : cnt_q[wr_idx_s] - 2'b01;
         end
      end else if (BranchUpdE && UpdTakenE) begin
         valid_d[wr_idx_s] = 1'b1;
         tag_d[wr_idx_s]   = wr_tag_s;
         tgt_d[wr_idx_s]   = UpdTargetE[WIDTH-1:2];
         cnt_d[wr_idx_s]   = 2'b10;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BTB_DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= {TAG_W{1'b0}};
            tgt_q[i]   <= {(WIDTH-2){1'b0}};
            cnt_q[i]   <= 2'b00;
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign pred_taken_s  = 1'b0;
   assign pred_target_s = pc_plus4_s;
   assign unused_s      = &{1'b0, BranchUpdE, UpdPCE, UpdTargetE, UpdTakenE, RedirectPCE[1:0]};
`endif

   // pred_target_s already falls back to PC+4 when nothing is predicted.
   always_comb begin
      pc_d = pc_q;
      if (RedirectE) begin
         pc_d = redirect_pc_s;
      end else if (StallF) begin
         pc_d = pc_q;
      end else begin
         pc_d = pred_target_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign PCF         = pc_q;
   assign PCPlus4F    = pc_plus4_s;
   assign PredTakenF  = pred_taken_s;
   assign PredTargetF = pred_target_s;

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC and target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0, PC value loaded on reset.
REQ-003 SHALL have parameter BTB_DEPTH, default 8, number of BTB entries; must be a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port StallF, input, 1, hold PCF this cycle.
REQ-007 SHALL have port RedirectE, input, 1, execute-stage redirect (mispredict or jalr).
REQ-008 SHALL have port RedirectPCE, input, WIDTH, redirect target.
REQ-009 SHALL have port BranchUpdE, input, 1, resolved control transfer in execute; BTB update strobe.
REQ-010 SHALL have port UpdPCE, input, WIDTH, PC of the resolved instruction.
REQ-011 SHALL have port UpdTargetE, input, WIDTH, resolved taken target.
REQ-012 SHALL have port UpdTakenE, input, 1, resolved direction (1 = taken).
REQ-013 SHALL have port PCF, output, WIDTH, current fetch PC (registered).
REQ-014 SHALL have port PCPlus4F, output, WIDTH, PCF + 4.
REQ-015 SHALL have port PredTakenF, output, 1, BTB predicts taken for PCF.
REQ-016 SHALL have port PredTargetF, output, WIDTH, predicted next PC.

Function
REQ-017 SHALL compute PCPlus4F = PCF + 4 combinationally, modulo 2^WIDTH (e.g. FFFF_FFFC wraps to 0000_0000).
REQ-018 SHALL select the next PC with priority RedirectE > StallF > PredTakenF > PCPlus4F; RedirectE overrides StallF.
REQ-019 SHALL force bits [1:0] of every loaded redirect or predicted target to 0.
REQ-020 SHALL implement the BTB as direct-mapped: index = PC[log2(BTB_DEPTH)+1:2], tag = PC[WIDTH-1:log2(BTB_DEPTH)+2]; each entry holds a valid bit, tag, target and a 2-bit saturating counter.
REQ-021 SHALL assert PredTakenF iff the indexed entry is valid, its tag matches PCF and counter[1] = 1; otherwise PredTakenF = 0 and PredTargetF = PCPlus4F.
REQ-022 SHALL apply BranchUpdE on a tag hit as follows: taken increments the counter (saturating at 3) and writes UpdTargetE; not-taken decrements the counter (saturating at 0) and leaves the target unchanged.
REQ-023 SHALL, on a BranchUpdE miss with UpdTakenE = 1, allocate or overwrite the entry with valid = 1, the new tag, UpdTargetE and counter = 2'b10; a not-taken miss SHALL NOT allocate.
REQ-024 SHALL read old BTB contents during a lookup that coincides with an update to the same entry (no write-to-read bypass); the new contents are visible from the next cycle.
REQ-025 SHALL process BranchUpdE independently of StallF and RedirectE in the same cycle.

Reset
REQ-026 SHALL, while rst = 1, asynchronously set PCF = RESET_VECTOR, clear all BTB valid bits and set all counters to 0.
REQ-027 SHALL, on the first rising clk edge after rst deasserts, follow the normal next-PC priority; a redirect or update in flight when rst asserts is discarded.

Configuration
REQ-028 SHALL include the BTB only when macro FETCH_PC_GEN_BTB_EN is defined.
REQ-029 SHALL, without FETCH_PC_GEN_BTB_EN, contain no BTB storage, tie PredTakenF = 0 and PredTargetF = PCPlus4F, and ignore BranchUpdE, UpdPCE, UpdTargetE and UpdTakenE; the next PC SHALL be RedirectE > StallF > PCPlus4F.

Verification
REQ-030 SHALL cover this reset case: rst pulse mid-run with RESET_VECTOR = 32'h100 -> PCF = 0x100 immediately (async), then 0x104 and 0x108 on the following edges.
REQ-031 SHALL cover stall versus redirect: StallF = 1 for 3 cycles at PCF = 0x20 -> PCF holds 0x20; StallF = 1 with RedirectE = 1 and RedirectPCE = 0x403 -> PCF = 0x400 next cycle.
REQ-032 SHALL cover BTB training (BTB_EN): a taken update at UpdPCE = 0x40 with UpdTargetE = 0x80 -> the next fetch of 0x40 gives PredTakenF = 1 and PCF = 0x80 on the following cycle.
REQ-033 SHALL cover counter saturation: the 0x40 entry with 4 taken updates, then 1 not-taken -> still predicts taken; after 2 further not-taken -> PredTakenF = 0 at 0x40.
REQ-034 SHALL cover alias replacement (BTB_DEPTH = 8): taken update at 0x40, then taken update at 0x60 (same index, different tag) -> fetch at 0x40 misses with PCF next = 0x44; fetch at 0x60 hits.
REQ-035 SHALL cover wrap-around and macro off: PCF = 0xFFFF_FFFC with no stall -> PCF = 0x0; without the macro, BranchUpdE pulses never produce PredTakenF = 1.
